run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
- Host-side sequencer that drives the processor's req/done handshake. It preloads data memory from an inbound byte stream, then issues req to the core.
- It waits for the core's done, then reads a result window back out of data memory onto an outbound byte stream.
- It sits outside top_level and owns the data-memory write/read port while the core is idle.

Parameters:
- AW, 8, data-memory address width; all addresses wrap modulo 2**AW.
- TO_W, 16, width of the core-wait timeout counter.
- TIMEOUT, 4000, maximum number of cycles spent in WAIT before abort (must be ≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a sequence; sampled only in IDLE
- load_base  in  AW  first data-memory address to preload
- load_len  in  8  number of bytes to preload; 0 = skip LOAD
- rd_base  in  AW  first data-memory address to read back
- rd_len  in  8  number of bytes to read back; 0 = skip DRAIN
- s_valid  in  1  inbound byte valid
- s_data  in  8  inbound byte
- s_ready  out  1  sequencer accepts inbound byte
- mem_wr_en  out  1  data-memory write enable
- mem_addr  out  AW  data-memory address
- mem_wr_dat  out  8  data-memory write data
- mem_rd_dat  in  8  data-memory combinational read data at mem_addr
- core_req  out  1  run request to core
- core_done  in  1  core completion, level
- m_valid  out  1  outbound byte valid
- m_data  out  8  outbound byte
- m_ready  in  1  downstream accepts outbound byte
- busy  out  1  high in any state except IDLE
- fin  out  1  one-cycle completion pulse
- timeout  out  1  sticky: last sequence aborted in WAIT

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, cnt=0, timer=0.
  - All outputs 0: s_ready, mem_wr_en, mem_addr, mem_wr_dat, core_req, m_valid, m_data, busy, fin, timeout.
  - Reset mid-sequence aborts immediately; any partial memory writes remain.
- States: IDLE, LOAD, RUN, WAIT, DRAIN, FINISH.
- IDLE:
  - On start=1, latch load_base, load_len, rd_base, rd_len; clear cnt and timeout.
  - Next state is LOAD if load_len≠0, else RUN.
  - start is ignored in every other state.
- LOAD:
  - s_ready=1.
  - A transfer occurs when s_valid&&s_ready. In the same cycle: mem_wr_en=1, mem_addr=load_base+cnt (mod 2**AW), mem_wr_dat=s_data. Then cnt++.
  - When the transfer with cnt==load_len-1 occurs, go to RUN with cnt cleared.
  - mem_wr_en=0 on cycles with no transfer.
- RUN: core_req=1 for exactly one cycle; timer cleared; go to WAIT.
- WAIT:
  - core_req=0; timer increments each cycle.
  - If core_done=1, go to DRAIN (rd_len≠0) or FINISH (rd_len==0).
  - Else if timer==TIMEOUT-1, set timeout=1 and go to FINISH, skipping DRAIN.
  - If core_done and timeout coincide in the same cycle, core_done wins.
- DRAIN:
  - mem_addr=rd_base+cnt (mod 2**AW); m_valid=1; m_data=mem_rd_dat, combinational.
  - While m_valid&&!m_ready, mem_addr and m_data hold stable.
  - On m_ready, cnt++. After the transfer with cnt==rd_len-1, go to FINISH.
  - mem_wr_en=0 throughout.
- FINISH: fin=1 for one cycle; go to IDLE.
- Address wrap: load_base=0xFE with load_len=4 writes addresses FE, FF, 00, 01. Same rule applies in DRAIN.
- Outputs outside their owning state are 0, except mem_addr and mem_wr_dat. Those may hold their last value but must be ignored when mem_wr_en=0.
- Latency, best case with continuous valid/ready:
  - IDLE→LOAD: 1 cycle.
  - LOAD: load_len cycles.
  - RUN: 1 cycle.
  - WAIT: ≥1 cycle.
  - DRAIN: rd_len cycles.
  - FINISH: 1 cycle.

Test Plan:
- Basic run: load_base=0x10, load_len=3, stream AA,BB,CC with s_valid held; core model asserts done 5 cycles after req; rd_base=0x10, rd_len=3, m_ready=1 -> writes AA/BB/CC to 10/11/12; core_req one pulse; m_data AA,BB,CC on 3 consecutive cycles; fin one pulse; timeout=0.
- Backpressure: s_valid toggled 1,0,1,0,1 and m_ready toggled 0,1,0,1,0,1 -> exactly 3 writes, no duplicates; m_data/mem_addr stable during stalls; byte order preserved.
- Zero lengths: load_len=0, rd_len=0, start -> IDLE, RUN, WAIT; on done go to FINISH; no mem_wr_en, no m_valid ever.
- Timeout: TIMEOUT=8, core_done held 0 -> WAIT lasts 8 cycles, timeout=1, fin pulses, no DRAIN. Next start clears timeout.
- Wrap and collision: load_base=0xFE, load_len=4 writes FE, FF, 00, 01. Separately, core_done asserted on the timeout cycle -> DRAIN entered, timeout=0.
- Reset mid-DRAIN: reset=0 for one cycle -> next cycle all outputs 0, state IDLE. start during busy is ignored: no restart and latched lengths unchanged.

Source files
------------

// File: rtl/run_sequencer.sv
// Host-side run sequencer: preloads data memory from a byte stream, kicks the core,
// waits for done (with timeout) and streams a result window back out.
module run_sequencer #(
    parameter int unsigned AW      = 8,
    parameter int unsigned TO_W    = 16,
    parameter int unsigned TIMEOUT = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] load_base,
    input  logic [7:0]    load_len,
    input  logic [AW-1:0] rd_base,
    input  logic [7:0]    rd_len,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wr_dat,
    input  logic [7:0]    mem_rd_dat,
    output logic          core_req,
    input  logic          core_done,
    output logic          m_valid,
    output logic [7:0]    m_data,
    input  logic          m_ready,
    output logic          busy,
    output logic          fin,
    output logic          timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_WAIT, S_DRAIN, S_FINISH
    } state_t;

    localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [AW-1:0] load_base_q, load_base_d;
    logic [7:0]    load_len_q, load_len_d;
    logic [AW-1:0] rd_base_q, rd_base_d;
    logic [7:0]    rd_len_q, rd_len_d;
    logic          timeout_q, timeout_d;
    logic          s_ready_q, s_ready_d;
    logic          core_req_q, core_req_d;
    logic          m_valid_q, m_valid_d;
    logic          busy_q, busy_d;
    logic          fin_q, fin_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    // Next-state, counters and the registered per-state strobes derived from state_d.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        load_base_d = load_base_q;
        load_len_d  = load_len_q;
        rd_base_d   = rd_base_q;
        rd_len_d    = rd_len_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_base_d = load_base;
                    load_len_d  = load_len;
                    rd_base_d   = rd_base;
                    rd_len_d    = rd_len;
                    cnt_d       = 8'd0;
                    timeout_d   = 1'b0;
                    state_d     = (load_len != 8'd0) ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: begin
                if (s_valid) begin
                    if (cnt_q == load_len_q - 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_RUN: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TO_W'(1);
                // done takes priority over a coincident timeout
                if (core_done) begin
                    state_d = (rd_len_q != 8'd0) ? S_DRAIN : S_FINISH;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end
            end
            S_DRAIN: begin
                if (m_ready) begin
                    if (cnt_q == rd_len_q - 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = S_FINISH;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        s_ready_d  = (state_d == S_LOAD);
        core_req_d = (state_d == S_RUN);
        m_valid_d  = (state_d == S_DRAIN);
        busy_d     = (state_d != S_IDLE);
        fin_d      = (state_d == S_FINISH);

        // Address is registered ahead so it is stable for the whole beat and during stalls.
        if (state_d == S_LOAD) begin
            mem_addr_d = load_base_d + AW'(cnt_d);
        end else if (state_d == S_DRAIN) begin
            mem_addr_d = rd_base_d + AW'(cnt_d);
        end else begin
            mem_addr_d = mem_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            timer_q     <= '0;
            load_base_q <= '0;
            load_len_q  <= 8'd0;
            rd_base_q   <= '0;
            rd_len_q    <= 8'd0;
            timeout_q   <= 1'b0;
            s_ready_q   <= 1'b0;
            core_req_q  <= 1'b0;
            m_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            load_base_q <= load_base_d;
            load_len_q  <= load_len_d;
            rd_base_q   <= rd_base_d;
            rd_len_q    <= rd_len_d;
            timeout_q   <= timeout_d;
            s_ready_q   <= s_ready_d;
            core_req_q  <= core_req_d;
            m_valid_q   <= m_valid_d;
            busy_q      <= busy_d;
            fin_q       <= fin_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // Stream-facing data paths pass through in the same cycle as the handshake.
    assign mem_wr_en  = s_ready_q & s_valid;
    assign mem_wr_dat = s_ready_q ? s_data : 8'h00;
    assign m_data     = m_valid_q ? mem_rd_dat : 8'h00;

    assign s_ready  = s_ready_q;
    assign mem_addr = mem_addr_q;
    assign core_req = core_req_q;
    assign m_valid  = m_valid_q;
    assign busy     = busy_q;
    assign fin      = fin_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: drives the streams and core handshake cycle by
// cycle and checks every handshake output against hand-derived expectations.
module tb_run_sequencer;

    localparam int unsigned TMO = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] load_base = 8'h00, load_len = 8'h00, rd_base = 8'h00, rd_len = 8'h00;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, mem_wr_en, core_req, m_valid, busy, fin, timeout;
    logic [7:0] mem_addr, mem_wr_dat, mem_rd_dat, m_data;
    logic       core_done = 1'b0;
    logic       m_ready = 1'b0;

    logic [7:0] mem     [0:255];
    logic [7:0] exp_mem [0:255];
    logic [7:0] src     [0:15];
    int         wr_cnt = 0;
    int         mv_cnt = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    run_sequencer #(.AW(8), .TO_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_base(load_base), .load_len(load_len), .rd_base(rd_base), .rd_len(rd_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_dat(mem_wr_dat),
        .mem_rd_dat(mem_rd_dat), .core_req(core_req), .core_done(core_done),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .fin(fin), .timeout(timeout)
    );

    // Data memory with combinational read, plus activity counters.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_dat;
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
        if (m_valid)   mv_cnt <= mv_cnt + 1;
    end
    assign mem_rd_dat = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " s_ready"}, 32'(s_ready), 0);
        chk({tag, " mem_wr_en"}, 32'(mem_wr_en), 0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " mem_wr_dat"}, 32'(mem_wr_dat), 0);
        chk({tag, " core_req"}, 32'(core_req), 0);
        chk({tag, " m_valid"}, 32'(m_valid), 0);
        chk({tag, " m_data"}, 32'(m_data), 0);
        chk({tag, " fin"}, 32'(fin), 0);
        chk({tag, " timeout"}, 32'(timeout), 0);
    endtask

    // One full sequence. w: WAIT cycle (1-based) on which core_done is seen; w>TMO never.
    // spam: keep start asserted with junk parameters while busy. abort_at>=0: reset in DRAIN.
    task automatic run_seq(input logic [7:0] lb, input logic [7:0] ll,
                           input logic [7:0] rb, input logic [7:0] rl,
                           input logic [15:0] sp, input logic [15:0] mp,
                           input int w, input bit exp_to, input bit spam, input int abort_at);
        int idx, k, guard, wr0, mv0;
        bit got_done;
        @(negedge clk);
        wr0 = wr_cnt;
        mv0 = mv_cnt;
        load_base = lb; load_len = ll; rd_base = rb; rd_len = rl;
        start = 1'b1;
        #1 chk("idle before start", 32'(busy), 0);
        @(negedge clk);
        start = spam;
        if (spam) begin
            load_base = 8'hAA; load_len = 8'd9; rd_base = 8'h77; rd_len = 8'd7;
        end
        #1 chk("busy after start", 32'(busy), 1);
        chk("timeout cleared", 32'(timeout), 0);

        idx = 0; k = 0; guard = 0;
        while (ll != 0 && idx < int'(ll) && guard < 64) begin
            s_valid = sp[k % 16];
            s_data  = src[idx];
            #1 chk("load s_ready", 32'(s_ready), 1);
            chk("load wr_en", 32'(mem_wr_en), 32'(s_valid));
            if (s_valid) begin
                chk("load addr", 32'(mem_addr), 32'(8'(lb + 8'(idx))));
                chk("load data", 32'(mem_wr_dat), 32'(src[idx]));
                exp_mem[8'(lb + 8'(idx))] = src[idx];
                idx++;
            end
            k++; guard++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("load count", 32'(idx), 32'(ll));

        #1 chk("run core_req", 32'(core_req), 1);
        chk("run s_ready", 32'(s_ready), 0);
        chk("run wr_en", 32'(mem_wr_en), 0);
        @(negedge clk);

        got_done = 1'b0;
        for (int c = 1; c <= int'(TMO); c++) begin
            core_done = (c == w);
            #1 chk("wait core_req", 32'(core_req), 0);
            chk("wait fin", 32'(fin), 0);
            chk("wait m_valid", 32'(m_valid), 0);
            @(negedge clk);
            core_done = 1'b0;
            if (c == w) begin
                got_done = 1'b1;
                break;
            end
        end
        chk("done vs timeout", 32'(got_done), 32'(!exp_to));

        idx = 0; k = 0; guard = 0;
        while (!exp_to && rl != 0 && idx < int'(rl) && guard < 64) begin
            m_ready = mp[k % 16];
            #1 chk("drain m_valid", 32'(m_valid), 1);
            chk("drain addr", 32'(mem_addr), 32'(8'(rb + 8'(idx))));
            chk("drain data", 32'(m_data), 32'(exp_mem[8'(rb + 8'(idx))]));
            chk("drain wr_en", 32'(mem_wr_en), 0);
            if (guard == abort_at) begin
                reset = 1'b0;
                m_ready = 1'b0;
                start = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                #1 chk_idle_outputs("after reset");
                return;
            end
            if (m_ready) idx++;
            k++; guard++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        start = 1'b0;
        if (!exp_to) chk("drain count", 32'(idx), 32'(rl));

        #1 chk("finish fin", 32'(fin), 1);
        chk("finish m_valid", 32'(m_valid), 0);
        chk("finish timeout", 32'(timeout), 32'(exp_to));
        chk("writes", 32'(wr_cnt - wr0), 32'(ll));
        if (exp_to || rl == 0) chk("no m_valid", 32'(mv_cnt - mv0), 0);
        @(negedge clk);
        #1 chk("fin one pulse", 32'(fin), 0);
        chk("back to idle", 32'(busy), 0);
        chk("timeout sticky", 32'(timeout), 32'(exp_to));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        #1 chk_idle_outputs("reset");
        reset = 1'b1;

        // basic run
        src[0] = 8'hAA; src[1] = 8'hBB; src[2] = 8'hCC;
        run_seq(8'h10, 8'd3, 8'h10, 8'd3, 16'hFFFF, 16'hFFFF, 5, 1'b0, 1'b0, -1);
        // backpressure on both streams
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
        run_seq(8'h20, 8'd3, 8'h20, 8'd3, 16'h5555, 16'hAAAA, 2, 1'b0, 1'b0, -1);
        // zero lengths
        run_seq(8'h00, 8'd0, 8'h00, 8'd0, 16'hFFFF, 16'hFFFF, 3, 1'b0, 1'b0, -1);
        // timeout, then the next start clears it
        src[0] = 8'h5A;
        run_seq(8'h50, 8'd1, 8'h50, 8'd2, 16'hFFFF, 16'hFFFF, 99, 1'b1, 1'b0, -1);
        // address wrap
        src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03; src[3] = 8'h04;
        run_seq(8'hFE, 8'd4, 8'hFE, 8'd4, 16'hFFFF, 16'hFFFF, 1, 1'b0, 1'b0, -1);
        // done coincides with the last timer cycle: done wins
        run_seq(8'h00, 8'd0, 8'hFF, 8'd2, 16'hFFFF, 16'hFFFF, int'(TMO), 1'b0, 1'b0, -1);
        // start held with junk parameters while busy must be ignored
        src[0] = 8'hC1; src[1] = 8'hC2;
        run_seq(8'h30, 8'd2, 8'h30, 8'd2, 16'hFFFF, 16'hFFFF, 3, 1'b0, 1'b1, -1);
        // reset while stalled in DRAIN
        src[0] = 8'hD1; src[1] = 8'hD2;
        run_seq(8'h40, 8'd2, 8'h41, 8'd2, 16'hFFFF, 16'h0000, 2, 1'b0, 1'b0, 2);
        @(negedge clk);
        #1 chk("idle after reset", 32'(busy), 0);
        chk("partial write kept", 32'(mem[8'h41]), 32'(8'hD2));
        // normal operation resumes after the abort
        src[0] = 8'hE7;
        run_seq(8'h60, 8'd1, 8'h60, 8'd1, 16'hFFFF, 16'hFFFF, 4, 1'b0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
